// File: rtl/ramb_rd_pkg.sv
// ramb_rd_pkg: shared FSM state type, width defaults and parity helper for the port-B streamer.
package ramb_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_LEN_W = 12;
    function automatic logic par_ok(input logic [7:0] data, input logic par, input logic odd);
        return par == (odd ? ~^data : ^data);
    endfunction
endpackage

// File: rtl/ramb_rd_skid2.sv
// ramb_rd_skid2: 2-entry synchronous FIFO holding {last, data} beats between the BRAM and the stream.
module ramb_rd_skid2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);
    logic [W-1:0] mem [2];
    logic wr_ptr, rd_ptr;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/ramb16_s9_rd_streamer.sv
// ramb16_s9_rd_streamer: reads a byte range from BRAM port B into a valid/ready stream.
// Optional parity checking on returned bytes is built when RAMB_RD_PARITY_CHK_EN is defined.
module ramb16_s9_rd_streamer
    import ramb_rd_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    addrb,
    output logic                 enb,
    output logic                 web,
    output logic                 ssrb,
    input  logic [7:0]           dob,
    input  logic                 dopb,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 par_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0] len_q, issued;
    logic inflight, inflight_last, zero_done, accept, pop, drained;
    logic [1:0] cnt;
    logic [8:0] head;

    assign accept = state == IDLE && start;
    assign pop = m_valid && m_ready;
    assign drained = !inflight && cnt == 2'd0;
    // A pop this cycle frees a slot, so reads keep flowing at one beat per cycle.
    assign enb = state == RUN && issued != len_q && ({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign addrb = base + issued[ADDR_W-1:0];
    assign web = 1'b0;
    assign ssrb = 1'b0;
    assign busy = state != IDLE;
    assign done = zero_done || (state == DRAIN && drained);
    assign m_valid = cnt != 2'd0;
    assign m_data = head[7:0];
    assign m_last = m_valid && head[8];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept && len != '0 ? RUN : IDLE;
            RUN:     state_nxt = issued == len_q ? DRAIN : RUN;
            DRAIN:   state_nxt = drained ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            base <= '0;
            len_q <= '0;
            issued <= '0;
            inflight <= 1'b0;
            inflight_last <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state <= state_nxt;
            inflight <= enb;
            inflight_last <= issued == len_q - LEN_W'(1);
            zero_done <= accept && len == '0;
            if (accept) begin
                base <= base_addr;
                len_q <= len;
                issued <= '0;
            end else if (enb) begin
                issued <= issued + LEN_W'(1);
            end
        end
    end

    ramb_rd_skid2 #(.W(9)) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .pop  (pop),
        .din  ({inflight_last, dob}),
        .dout (head),
        .cnt  (cnt)
    );

`ifdef RAMB_RD_PARITY_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            par_err <= 1'b0;
            err_cnt <= '0;
        end else if (inflight && !par_ok(dob, dopb, PARITY_ODD != 0)) begin
            par_err <= 1'b1;
            if (!(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    logic unused_par;
    assign unused_par = dopb ^ (PARITY_ODD != 0);
    assign par_err = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ramb16_s9_rd_streamer.sv
// tb_ramb16_s9_rd_streamer: randomized scoreboard bench with a behavioural BRAM and byte-range model.
// Parity expectations follow RAMB_RD_PARITY_CHK_EN.
module tb_ramb16_s9_rd_streamer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] len = '0;
    logic busy, done, enb, web, ssrb, m_valid, m_last, par_err;
    logic [10:0] addrb;
    logic [7:0] m_data, err_cnt;
    logic [7:0] dob = '0;
    logic dopb = 1'b0;
    logic [8:0] mem [2048];
    logic [8:0] exp_q [$];
    logic [10:0] addr_log [$];
    int vectors = 0, miscompares = 0, cyc = 0;
    int done_cnt = 0, enb_cnt = 0, hs_cnt = 0, done_cyc = 0, last_hs_cyc = 0, outstanding = 0;
    int ready_mode = 0;

    ramb16_s9_rd_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .addrb(addrb), .enb(enb), .web(web), .ssrb(ssrb),
        .dob(dob), .dopb(dopb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .par_err(par_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (enb) begin
        dob <= mem[addrb][7:0];
        dopb <= mem[addrb][8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        int rp = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = (rp % 3 == 0); rp++; end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic stall_prev = 1'b0;
        logic [8:0] held = '0, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_beat", {m_last, m_data}, held);
                end
                if (enb) begin
                    enb_cnt++;
                    addr_log.push_back(addrb);
                    chk("issue_room", (outstanding - int'(m_valid && m_ready)) < 2, 1);
                    outstanding++;
                end
                if (m_valid && m_ready) begin
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("beat", {m_last, m_data}, e);
                    end
                    last_hs_cyc = cyc;
                    hs_cnt++;
                    outstanding--;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                stall_prev = m_valid && !m_ready;
                held = {m_last, m_data};
            end
        end
    end

    task automatic run_xfer(input logic [10:0] b, input logic [11:0] l, input bit timing, input bit inject);
        int d0, t, first_c;
        logic v0, v1, v2;
        for (int i = 0; i < int'(l); i++) exp_q.push_back({i == int'(l) - 1, mem[11'(b + 11'(i))][7:0]});
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b1; base_addr = b; len = l;
        @(posedge clk);
        #1 start = 1'b0;
        if (timing) begin
            @(negedge clk) v0 = m_valid;
            @(negedge clk) v1 = m_valid;
            @(negedge clk) v2 = m_valid;
            first_c = cyc;
            chk("first_valid_latency", {v0, v1, v2}, 3'b001);
        end
        if (inject) begin
            @(posedge clk);
            #1 start = 1'b1; base_addr = 11'h300; len = 12'd9;
            @(posedge clk);
            #1 start = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        if (timing) begin
            chk("back_to_back", last_hs_cyc - first_c, int'(l) - 1);
            chk("done_after_last", done_cyc - last_hs_cyc, 1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after", busy, 0);
        chk("single_done", done_cnt - d0, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int d0, e0, h0, t;
        logic [7:0] by;
        for (int i = 0; i < 2048; i++) begin
            by = 8'($urandom);
            mem[i] = {^by, by};
        end
        mem[16] = {^8'h11, 8'h11};
        mem[17] = {^8'h22, 8'h22};
        mem[18] = {^8'h33, 8'h33};
        mem[19] = {^8'h44, 8'h44};
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_outputs", {busy, done, enb, m_valid, m_last, par_err, web, ssrb}, 0);
            chk("rst_addrb", addrb, 0);
            chk("rst_err_cnt", err_cnt, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        ready_mode = 0;
        run_xfer(11'h010, 12'd4, 1'b1, 1'b0);
        chk("stream_par_err", par_err, 0);

        ready_mode = 1;
        run_xfer(11'h010, 12'd4, 1'b0, 1'b0);
        run_xfer(11'h100, 12'd20, 1'b0, 1'b0);

        ready_mode = 0;
        addr_log.delete();
        run_xfer(11'h7FE, 12'd4, 1'b0, 1'b0);
        chk("wrap_count", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("wrap_addr", addr_log[i], 11'(11'h7FE + 11'(i)));

        ready_mode = 1;
        run_xfer(11'h020, 12'd6, 1'b0, 1'b1);

        e0 = enb_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1 start = 1'b1; base_addr = 11'd5; len = 12'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("zero_len_done", done, 1);
        chk("zero_len_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("zero_len_no_enb", enb_cnt - e0, 0);
        chk("zero_len_one_done", done_cnt - d0, 1);

        ready_mode = 0;
        mem[11'h040] = {1'b0, 8'h01};
        run_xfer(11'h040, 12'd1, 1'b0, 1'b0);
`ifdef RAMB_RD_PARITY_CHK_EN
        chk("par_err_set", par_err, 1);
        chk("err_cnt_one", err_cnt, 1);
`else
        chk("par_err_off", par_err, 0);
        chk("err_cnt_off", err_cnt, 0);
`endif
        run_xfer(11'h010, 12'd4, 1'b0, 1'b0);
        chk("par_err_cleared", par_err, 0);
        chk("err_cnt_cleared", err_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            by = 8'($urandom);
            mem[11'h500 + i] = {~^by, by};
        end
        run_xfer(11'h500, 12'd300, 1'b0, 1'b0);
`ifdef RAMB_RD_PARITY_CHK_EN
        chk("err_cnt_saturate", err_cnt, 255);
        chk("par_err_sticky", par_err, 1);
`else
        chk("err_cnt_saturate_off", err_cnt, 0);
        chk("par_err_sticky_off", par_err, 0);
`endif

        ready_mode = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, mem[11'h060 + i][7:0]});
        h0 = hs_cnt;
        @(posedge clk);
        #1 start = 1'b1; base_addr = 11'h060; len = 12'd8;
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (hs_cnt - h0 < 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("abort_two_beats", hs_cnt - h0 >= 2, 1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        exp_q.delete();
        @(negedge clk);
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        ready_mode = 0;
        run_xfer(11'h060, 12'd8, 1'b1, 1'b0);

        ready_mode = 2;
        repeat (6) run_xfer(11'($urandom_range(0, 2047)), 12'($urandom_range(1, 40)), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
